// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the data-memory port between the core and the loader
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  c_req_i,
    input  logic                  c_we_i,
    input  logic [ADDR_WIDTH-1:0] c_addr_i,
    input  logic [DATA_WIDTH-1:0] c_wdata_i,
    output logic                  c_gnt_o,
    output logic                  c_rvalid_o,
    output logic                  c_stall_o,
    input  logic                  l_req_i,
    input  logic                  l_we_i,
    input  logic [ADDR_WIDTH-1:0] l_addr_i,
    input  logic [DATA_WIDTH-1:0] l_wdata_i,
    output logic                  l_gnt_o,
    output logic                  l_rvalid_o,
    input  logic                  l_lock_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t                state_q, state_d;
    logic                  owner_q, rr_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  c_rvalid_q, l_rvalid_q;
    logic                  elig_c, elig_l, win_l;

    // owner/rr encoding: 0 = core, 1 = loader; loader wins only if core is not eligible or won last
    assign elig_c = c_req_i & ~l_lock_i;
    assign elig_l = l_req_i;
    assign win_l  = elig_l & (~elig_c | ~rr_q);

    // next-state: one command at a time, reads always pass through WAIT for the capture
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (elig_c | elig_l) ? ISSUE : IDLE;
            ISSUE:   state_d = we_q ? IDLE : WAIT;
            WAIT:    state_d = (cnt_q == '0) ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // command capture, read-latency countdown and read-data return
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q    <= 1'b0;
            rr_q       <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            c_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
        end else begin
            c_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            if (state_q == IDLE && (elig_c | elig_l)) begin
                owner_q <= win_l;
                rr_q    <= win_l;
                we_q    <= win_l ? l_we_i : c_we_i;
                addr_q  <= win_l ? l_addr_i : c_addr_i;
                wdata_q <= win_l ? l_wdata_i : c_wdata_i;
            end
            if (state_q == ISSUE && !we_q) cnt_q <= CNT_WIDTH'(RD_LAT - 1);
            if (state_q == WAIT) begin
                if (cnt_q == '0) begin
                    rdata_q    <= mem_rdata_i;
                    c_rvalid_q <= ~owner_q;
                    l_rvalid_q <= owner_q;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign mem_en_o    = state_q == ISSUE;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign c_gnt_o     = mem_en_o & ~owner_q;
    assign l_gnt_o     = mem_en_o & owner_q;
    assign c_rvalid_o  = c_rvalid_q;
    assign l_rvalid_o  = l_rvalid_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = state_q != IDLE;
    assign c_stall_o   = c_req_i & ~(c_gnt_o & c_we_i) & ~c_rvalid_o;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scenario tasks plus grant/read scoreboard for two arbiter instances (RD_LAT 1 and 4)
module tb_dmem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, c_req, c_we, l_req, l_we, l_lock;
    logic [11:0] c_addr, l_addr;
    logic [31:0] c_wdata, l_wdata;
    logic [1:0]  c_gnt, c_rvalid, c_stall, l_gnt, l_rvalid, mem_en, mem_we, busy;
    logic [11:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [31:0] rdata [2];
    bit   [31:0] store [2][4096];
    bit          wv [2][4096];
    bit   [3:0]  pv [2];
    bit   [31:0] pd [2][4];
    logic        ovr_en;
    logic [31:0] ovr_val;
    int          checks = 0, errors = 0;
    bit          sb_on = 1'b0;

    typedef struct {logic port; logic we; logic [11:0] addr; logic [31:0] data;} txn_t;
    txn_t gq[$];
    txn_t rq[$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 4;
        dmem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RD_LAT(LAT), .CNT_WIDTH(4)) u_dut (
            .clk_i(clk), .rst_ni(rst_n),
            .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
            .c_gnt_o(c_gnt[g]), .c_rvalid_o(c_rvalid[g]), .c_stall_o(c_stall[g]),
            .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
            .l_gnt_o(l_gnt[g]), .l_rvalid_o(l_rvalid[g]), .l_lock_i(l_lock),
            .rdata_o(rdata[g]), .mem_en_o(mem_en[g]), .mem_we_o(mem_we[g]),
            .mem_addr_o(mem_addr[g]), .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(mem_rdata[g]),
            .busy_o(busy[g]));
        assign mem_rdata[g] = pv[g][LAT-1] ? pd[g][LAT-1] : 32'hBAD00BAD;
    end

    function automatic logic [31:0] pat(input logic [11:0] a);
        return {20'hA5A5A, a};
    endfunction

    // memory model: read data is valid only exactly LAT cycles after the strobe
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_en[k] && mem_we[k]) begin
                store[k][mem_addr[k]] <= mem_wdata[k];
                wv[k][mem_addr[k]]    <= 1'b1;
            end
            pv[k] <= {pv[k][2:0], mem_en[k] & ~mem_we[k]};
            for (int j = 3; j > 0; j--) pd[k][j] <= pd[k][j-1];
            pd[k][0] <= ovr_en ? ovr_val : (wv[k][mem_addr[k]] ? store[k][mem_addr[k]] : pat(mem_addr[k]));
        end
    end

    // scoreboard on instance 0: every grant and every rvalid must match the next expected entry
    always @(negedge clk) begin
        txn_t t;
        if (sb_on && (c_gnt[0] || l_gnt[0])) begin
            checks++;
            if (gq.size() == 0) begin
                errors++; $display("FAIL sb_gnt: unexpected grant c=%b l=%b", c_gnt[0], l_gnt[0]);
            end else begin
                t = gq.pop_front();
                if ({l_gnt[0], mem_we[0], mem_addr[0], mem_wdata[0]} !== {t.port, t.we, t.addr, t.data}) begin
                    errors++; $display("FAIL sb_gnt: got port=%b we=%b addr=%h wdata=%h want port=%b we=%b addr=%h wdata=%h",
                        l_gnt[0], mem_we[0], mem_addr[0], mem_wdata[0], t.port, t.we, t.addr, t.data);
                end
            end
        end
        if (sb_on && (c_rvalid[0] || l_rvalid[0])) begin
            checks++;
            if (rq.size() == 0) begin
                errors++; $display("FAIL sb_rd: unexpected rvalid c=%b l=%b", c_rvalid[0], l_rvalid[0]);
            end else begin
                t = rq.pop_front();
                if ({l_rvalid[0], rdata[0]} !== {t.port, t.data}) begin
                    errors++; $display("FAIL sb_rd: got port=%b rdata=%h want port=%b rdata=%h", l_rvalid[0], rdata[0], t.port, t.data);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        sb_on = 1'b0;
        rst_n = 1'b0;
        {c_req, c_we, l_req, l_we, l_lock, ovr_en} = '0;
        {c_addr, l_addr, c_wdata, l_wdata, ovr_val} = '0;
        gq.delete();
        rq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {c_we, l_req, l_we, l_lock, ovr_en} = '0;
        {c_addr, l_addr, c_wdata, l_wdata, ovr_val} = '0;
        c_req = 1'b1;
        mid();
        checks++; if ({busy, mem_en, c_gnt, l_gnt, c_rvalid, l_rvalid} !== 12'h0) begin errors++; $display("FAIL rst_outs: got %h want 000", {busy, mem_en, c_gnt, l_gnt, c_rvalid, l_rvalid}); end
        checks++; if ({rdata[0], mem_addr[0], mem_wdata[0]} !== 76'h0) begin errors++; $display("FAIL rst_regs: got %h want 0", {rdata[0], mem_addr[0], mem_wdata[0]}); end
        checks++; if (c_stall !== 2'b11) begin errors++; $display("FAIL rst_stall_hi: got %b want 11", c_stall); end
        c_req = 1'b0;
        #1;
        checks++; if (c_stall !== 2'b00) begin errors++; $display("FAIL rst_stall_lo: got %b want 00", c_stall); end
        do_reset();
    endtask

    task automatic test_core_load();
        do_reset();
        sb_on = 1'b1;
        ovr_en = 1'b1; ovr_val = 32'hDEADBEEF;
        c_req = 1'b1; c_we = 1'b0; c_addr = 12'h010; c_wdata = 32'h0;
        gq.push_back('{port: 1'b0, we: 1'b0, addr: 12'h010, data: 32'h0});
        rq.push_back('{port: 1'b0, we: 1'b0, addr: 12'h010, data: 32'hDEADBEEF});
        mid();
        checks++; if ({c_stall[0], c_gnt[0], busy[0]} !== 3'b100) begin errors++; $display("FAIL load_t0: got %b want 100", {c_stall[0], c_gnt[0], busy[0]}); end
        cyc(); mid();
        checks++; if ({c_gnt[0], mem_en[0], mem_we[0], c_stall[0]} !== 4'b1101) begin errors++; $display("FAIL load_t1: got %b want 1101", {c_gnt[0], mem_en[0], mem_we[0], c_stall[0]}); end
        cyc(); mid();
        checks++; if ({c_gnt[0], busy[0], c_rvalid[0], c_stall[0]} !== 4'b0101) begin errors++; $display("FAIL load_t2: got %b want 0101", {c_gnt[0], busy[0], c_rvalid[0], c_stall[0]}); end
        cyc(); mid();
        checks++; if ({c_rvalid[0], c_stall[0], busy[0]} !== 3'b100) begin errors++; $display("FAIL load_t3: got %b want 100", {c_rvalid[0], c_stall[0], busy[0]}); end
        checks++; if (rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got %h want deadbeef", rdata[0]); end
        #1 c_req = 1'b0; ovr_en = 1'b0;
        cyc(); mid();
        checks++; if ({busy[0], rdata[0]} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL load_t4: got %h want 0deadbeef", {busy[0], rdata[0]}); end
        checks++; if (gq.size() + rq.size() != 0) begin errors++; $display("FAIL load_sb_left: got %0d want 0", gq.size() + rq.size()); end
    endtask

    task automatic test_rr_writes();
        logic [2:0] exp;
        do_reset();
        sb_on = 1'b1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 12'h100; c_wdata = 32'hC000_0000;
        l_req = 1'b1; l_we = 1'b1; l_addr = 12'h200; l_wdata = 32'hD000_0000;
        gq.push_back('{port: 1'b0, we: 1'b1, addr: 12'h100, data: 32'hC000_0000});
        gq.push_back('{port: 1'b1, we: 1'b1, addr: 12'h200, data: 32'hD000_0000});
        gq.push_back('{port: 1'b0, we: 1'b1, addr: 12'h101, data: 32'hC000_0001});
        gq.push_back('{port: 1'b1, we: 1'b1, addr: 12'h201, data: 32'hD000_0001});
        for (int t = 0; t < 8; t++) begin
            if (t != 0) cyc();
            mid();
            exp = (t % 4 == 1) ? 3'b101 : (t % 4 == 3) ? 3'b011 : 3'b000;
            checks++; if ({c_gnt[0], l_gnt[0], busy[0]} !== exp) begin errors++; $display("FAIL rr_t%0d: got %b want %b", t, {c_gnt[0], l_gnt[0], busy[0]}, exp); end
            if (t % 4 == 1) begin c_addr = c_addr + 1; c_wdata = c_wdata + 1; end
            if (t % 4 == 3) begin l_addr = l_addr + 1; l_wdata = l_wdata + 1; end
        end
        c_req = 1'b0; l_req = 1'b0;
        cyc(); mid();
        checks++; if (busy[0] !== 1'b0 || gq.size() != 0) begin errors++; $display("FAIL rr_end: got busy=%b left=%0d want busy=0 left=0", busy[0], gq.size()); end
    endtask

    task automatic test_lock();
        logic [1:0] exp;
        do_reset();
        sb_on = 1'b1;
        l_lock = 1'b1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 12'h020;
        l_req = 1'b1; l_we = 1'b0; l_addr = 12'h030;
        gq.push_back('{port: 1'b1, we: 1'b0, addr: 12'h030, data: 32'h0});
        gq.push_back('{port: 1'b0, we: 1'b0, addr: 12'h020, data: 32'h0});
        rq.push_back('{port: 1'b1, we: 1'b0, addr: 12'h030, data: pat(12'h030)});
        rq.push_back('{port: 1'b0, we: 1'b0, addr: 12'h020, data: pat(12'h020)});
        for (int t = 0; t < 6; t++) begin
            if (t != 0) cyc();
            mid();
            exp = (t == 1) ? 2'b10 : (t == 3) ? 2'b01 : 2'b00;
            checks++; if ({c_gnt[0], c_stall[0], l_gnt[0], l_rvalid[0]} !== {2'b01, exp}) begin errors++; $display("FAIL lock_t%0d: got %b want %b", t, {c_gnt[0], c_stall[0], l_gnt[0], l_rvalid[0]}, {2'b01, exp}); end
            if (t == 3) l_req = 1'b0;
        end
        cyc();
        l_lock = 1'b0;
        mid();
        checks++; if ({c_gnt[0], c_stall[0]} !== 2'b01) begin errors++; $display("FAIL unlock_t6: got %b want 01", {c_gnt[0], c_stall[0]}); end
        cyc(); mid();
        checks++; if (c_gnt[0] !== 1'b1) begin errors++; $display("FAIL unlock_gnt: got %b want 1", c_gnt[0]); end
        for (int n = 0; n < 6 && c_rvalid[0] !== 1'b1; n++) begin cyc(); mid(); end
        checks++; if ({c_rvalid[0], c_stall[0]} !== 2'b10) begin errors++; $display("FAIL unlock_rvalid: got %b want 10", {c_rvalid[0], c_stall[0]}); end
        #1 c_req = 1'b0;
        cyc(); mid();
        checks++; if (gq.size() + rq.size() != 0) begin errors++; $display("FAIL lock_sb_left: got %0d want 0", gq.size() + rq.size()); end
    endtask

    task automatic test_long_latency();
        logic [4:0] exp;
        do_reset();
        l_req = 1'b1; l_we = 1'b0; l_addr = 12'h7F0;
        for (int t = 0; t < 8; t++) begin
            if (t != 0) cyc();
            if (t == 2) begin c_req = 1'b1; c_we = 1'b0; c_addr = 12'h040; end
            mid();
            exp = {t == 1 || t == 7, t == 1, t == 6, t == 7, (t >= 1 && t <= 5) || t == 7};
            checks++; if ({mem_en[1], l_gnt[1], l_rvalid[1], c_gnt[1], busy[1]} !== exp) begin errors++; $display("FAIL lat4_t%0d: got %b want %b", t, {mem_en[1], l_gnt[1], l_rvalid[1], c_gnt[1], busy[1]}, exp); end
            if (t == 5) begin checks++; if (rdata[1] !== 32'h0) begin errors++; $display("FAIL lat4_early: got %h want 0", rdata[1]); end end
            if (t == 6) begin checks++; if (rdata[1] !== pat(12'h7F0)) begin errors++; $display("FAIL lat4_rdata: got %h want %h", rdata[1], pat(12'h7F0)); end end
            if (t == 7) begin checks++; if (mem_addr[1] !== 12'h040) begin errors++; $display("FAIL lat4_caddr: got %h want 040", mem_addr[1]); end end
            if (t == 1) l_req = 1'b0;
        end
        c_req = 1'b0;
        for (int n = 0; n < 10 && c_rvalid[1] !== 1'b1; n++) begin cyc(); mid(); end
        checks++; if ({c_rvalid[1], rdata[1]} !== {1'b1, pat(12'h040)}) begin errors++; $display("FAIL lat4_core_rd: got %h want %h", {c_rvalid[1], rdata[1]}, {1'b1, pat(12'h040)}); end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 12'h050;
        mid();
        cyc(); mid();
        checks++; if ({c_gnt, mem_en} !== 4'b1111) begin errors++; $display("FAIL rstw_gnt: got %b want 1111", {c_gnt, mem_en}); end
        c_req = 1'b0;
        cyc(); mid();
        checks++; if (busy !== 2'b11) begin errors++; $display("FAIL rstw_busy: got %b want 11", busy); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({busy, mem_en, c_gnt, l_gnt, c_rvalid, l_rvalid} !== 12'h0) begin errors++; $display("FAIL rstw_async: got %h want 000", {busy, mem_en, c_gnt, l_gnt, c_rvalid, l_rvalid}); end
        cyc();
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            mid();
            checks++; if ({c_rvalid, l_rvalid, busy} !== 6'h0) begin errors++; $display("FAIL rstw_stale_%0d: got %b want 000000", n, {c_rvalid, l_rvalid, busy}); end
            cyc();
        end
        c_req = 1'b1; c_we = 1'b0; c_addr = 12'h060;
        l_req = 1'b1; l_we = 1'b0; l_addr = 12'h070;
        mid();
        cyc(); mid();
        checks++; if ({c_gnt, l_gnt, mem_en} !== 6'b110011) begin errors++; $display("FAIL rstw_tie: got %b want 110011", {c_gnt, l_gnt, mem_en}); end
        #1 rst_n = 1'b0; c_req = 1'b0; l_req = 1'b0;
        #1;
        checks++; if ({mem_en, c_gnt, busy} !== 6'h0) begin errors++; $display("FAIL rsti_async: got %b want 000000", {mem_en, c_gnt, busy}); end
        cyc();
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            mid();
            checks++; if ({c_rvalid, l_rvalid, busy} !== 6'h0) begin errors++; $display("FAIL rsti_stale_%0d: got %b want 000000", n, {c_rvalid, l_rvalid, busy}); end
            cyc();
        end
    endtask

    task automatic test_core_store();
        do_reset();
        sb_on = 1'b1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 12'h004; c_wdata = 32'h12345678;
        gq.push_back('{port: 1'b0, we: 1'b1, addr: 12'h004, data: 32'h12345678});
        mid();
        checks++; if ({c_stall[0], busy[0]} !== 2'b10) begin errors++; $display("FAIL store_t0: got %b want 10", {c_stall[0], busy[0]}); end
        cyc(); mid();
        checks++; if ({mem_en[0], mem_we[0], c_gnt[0], c_stall[0]} !== 4'b1110) begin errors++; $display("FAIL store_t1: got %b want 1110", {mem_en[0], mem_we[0], c_gnt[0], c_stall[0]}); end
        c_req = 1'b0;
        cyc(); mid();
        checks++; if ({busy[0], mem_en[0], mem_we[0]} !== 3'b001) begin errors++; $display("FAIL store_t2: got %b want 001", {busy[0], mem_en[0], mem_we[0]}); end
        c_req = 1'b1; c_we = 1'b0;
        gq.push_back('{port: 1'b0, we: 1'b0, addr: 12'h004, data: 32'h12345678});
        rq.push_back('{port: 1'b0, we: 1'b0, addr: 12'h004, data: 32'h12345678});
        for (int n = 0; n < 6 && c_rvalid[0] !== 1'b1; n++) begin cyc(); mid(); end
        checks++; if ({c_rvalid[0], rdata[0]} !== {1'b1, 32'h12345678}) begin errors++; $display("FAIL store_readback: got %h want 112345678", {c_rvalid[0], rdata[0]}); end
        #1 c_req = 1'b0;
        cyc(); mid();
        checks++; if (gq.size() + rq.size() != 0) begin errors++; $display("FAIL store_sb_left: got %0d want 0", gq.size() + rq.size()); end
        sb_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_core_load();
        test_rr_writes();
        test_lock();
        test_long_latency();
        test_reset_in_wait();
        test_core_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
